// File: rtl/t03_wb_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : t03_wb_request_arbiter_if
// Brief    : Bundle of the two requester ports and the manager CPU-side port
//            seen by t03_wb_request_arbiter. The slave modport is the
//            arbiter's view; the master modport is the surrounding
//            fetch/data units plus the bus manager.
// Revision : 1.0 - initial release
// ============================================================================
interface t03_wb_request_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
);

  // Port 0 (instruction fetch)
  logic              r0_req_i;
  logic              r0_we_i;
  logic [ADDR_W-1:0] r0_adr_i;
  logic [DATA_W-1:0] r0_dat_i;
  logic [SEL_W-1:0]  r0_sel_i;
  logic [DATA_W-1:0] r0_dat_o;
  logic              r0_ack_o;

  // Port 1 (data load/store)
  logic              r1_req_i;
  logic              r1_we_i;
  logic [ADDR_W-1:0] r1_adr_i;
  logic [DATA_W-1:0] r1_dat_i;
  logic [SEL_W-1:0]  r1_sel_i;
  logic [DATA_W-1:0] r1_dat_o;
  logic              r1_ack_o;

  // Manager CPU-side port
  logic [ADDR_W-1:0] m_adr_o;
  logic [DATA_W-1:0] m_dat_o;
  logic [SEL_W-1:0]  m_sel_o;
  logic              m_write_o;
  logic              m_read_o;
  logic [DATA_W-1:0] m_dat_i;
  logic              m_ack_i;
  logic              m_busy_i;

  // Current owner, one-hot
  logic [1:0]        grant_o;

  modport slave (
    input  r0_req_i, r0_we_i, r0_adr_i, r0_dat_i, r0_sel_i,
    output r0_dat_o, r0_ack_o,
    input  r1_req_i, r1_we_i, r1_adr_i, r1_dat_i, r1_sel_i,
    output r1_dat_o, r1_ack_o,
    output m_adr_o, m_dat_o, m_sel_o, m_write_o, m_read_o,
    input  m_dat_i, m_ack_i, m_busy_i,
    output grant_o
  );

  modport master (
    output r0_req_i, r0_we_i, r0_adr_i, r0_dat_i, r0_sel_i,
    input  r0_dat_o, r0_ack_o,
    output r1_req_i, r1_we_i, r1_adr_i, r1_dat_i, r1_sel_i,
    input  r1_dat_o, r1_ack_o,
    input  m_adr_o, m_dat_o, m_sel_o, m_write_o, m_read_o,
    output m_dat_i, m_ack_i, m_busy_i,
    input  grant_o
  );

endinterface
`default_nettype wire

// File: rtl/t03_wb_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : t03_wb_request_arbiter
// Brief    : Shares the single Wishbone manager CPU-side port between the
//            instruction-fetch requester (port 0) and the data requester
//            (port 1). One transaction in flight at a time:
//            IDLE -> ISSUE -> WAIT -> CAPTURE -> DONE -> IDLE.
//            All outputs are registered.
// Config   : T03_WB_ARB_FIXED_PRIO_EN defined   -> port 1 always wins ties,
//                                                  no round-robin pointer.
//            T03_WB_ARB_FIXED_PRIO_EN undefined -> round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module t03_wb_request_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input wire                       CLK,
  input wire                       RST,
  t03_wb_request_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Registered copies of everything that leaves the block
  logic [1:0]        r_grant,   w_grant_nxt;
  logic              r_we,      w_we_nxt;
  logic [ADDR_W-1:0] r_m_adr,   w_m_adr_nxt;
  logic [DATA_W-1:0] r_m_dat,   w_m_dat_nxt;
  logic [SEL_W-1:0]  r_m_sel,   w_m_sel_nxt;
  logic              r_m_write, w_m_write_nxt;
  logic              r_m_read,  w_m_read_nxt;
  logic [DATA_W-1:0] r_r0_dat,  w_r0_dat_nxt;
  logic [DATA_W-1:0] r_r1_dat,  w_r1_dat_nxt;
  logic              r_r0_ack,  w_r0_ack_nxt;
  logic              r_r1_ack,  w_r1_ack_nxt;

`ifndef T03_WB_ARB_FIXED_PRIO_EN
  // Port that won the most recent grant; reset to 1 so port 0 wins the first tie
  logic              r_last,    w_last_nxt;
`endif

  // Arbitration result and the winner's request fields
  logic              w_any_req;
  logic              w_pick1;
  logic              w_pick_we;
  logic [ADDR_W-1:0] w_pick_adr;
  logic [DATA_W-1:0] w_pick_dat;
  logic [SEL_W-1:0]  w_pick_sel;

  // Winner selection: fixed priority to port 1, or alternate on a tie
  always_comb begin
    w_any_req = bus.r0_req_i | bus.r1_req_i;
`ifdef T03_WB_ARB_FIXED_PRIO_EN
    w_pick1   = bus.r1_req_i;
`else
    if (bus.r0_req_i && bus.r1_req_i) begin
      w_pick1 = ~r_last;
    end else begin
      w_pick1 = bus.r1_req_i;
    end
`endif
  end

  // Mux the winning requester's command fields
  always_comb begin
    if (w_pick1) begin
      w_pick_we  = bus.r1_we_i;
      w_pick_adr = bus.r1_adr_i;
      w_pick_dat = bus.r1_dat_i;
      w_pick_sel = bus.r1_sel_i;
    end else begin
      w_pick_we  = bus.r0_we_i;
      w_pick_adr = bus.r0_adr_i;
      w_pick_dat = bus.r0_dat_i;
      w_pick_sel = bus.r0_sel_i;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_we_nxt      = r_we;
    w_m_adr_nxt   = r_m_adr;
    w_m_dat_nxt   = r_m_dat;
    w_m_sel_nxt   = r_m_sel;
    w_m_write_nxt = 1'b0;
    w_m_read_nxt  = 1'b0;
    w_r0_dat_nxt  = r_r0_dat;
    w_r1_dat_nxt  = r_r1_dat;
    w_r0_ack_nxt  = 1'b0;
    w_r1_ack_nxt  = 1'b0;
`ifndef T03_WB_ARB_FIXED_PRIO_EN
    w_last_nxt    = r_last;
`endif

    case (r_state)
      ST_IDLE: begin
        // A busy manager is still draining the previous cycle: hold off
        if (!bus.m_busy_i && w_any_req) begin
          w_state_nxt   = ST_ISSUE;
          w_grant_nxt   = w_pick1 ? 2'b10 : 2'b01;
          w_we_nxt      = w_pick_we;
          w_m_adr_nxt   = w_pick_adr;
          w_m_dat_nxt   = w_pick_dat;
          w_m_sel_nxt   = w_pick_sel;
          // Start pulse is registered so it is visible exactly in ISSUE
          w_m_write_nxt = w_pick_we;
          w_m_read_nxt  = ~w_pick_we;
`ifndef T03_WB_ARB_FIXED_PRIO_EN
          w_last_nxt    = w_pick1;
`endif
        end
      end

      ST_ISSUE: begin
        // Manager ack cannot belong to this transaction yet; ignore it
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.m_ack_i) begin
          w_state_nxt = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        // Manager read data is registered: valid the cycle after its ack
        if (!r_we) begin
          if (r_grant[1]) begin
            w_r1_dat_nxt = bus.m_dat_i;
          end else begin
            w_r0_dat_nxt = bus.m_dat_i;
          end
        end
        w_r0_ack_nxt = r_grant[0];
        w_r1_ack_nxt = r_grant[1];
        w_state_nxt  = ST_DONE;
      end

      ST_DONE: begin
        // Release the bus; re-arbitration happens in the following IDLE cycle
        w_grant_nxt = 2'b00;
        w_we_nxt    = 1'b0;
        w_m_adr_nxt = '0;
        w_m_dat_nxt = '0;
        w_m_sel_nxt = '0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output and command registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_grant   <= 2'b00;
      r_we      <= 1'b0;
      r_m_adr   <= '0;
      r_m_dat   <= '0;
      r_m_sel   <= '0;
      r_m_write <= 1'b0;
      r_m_read  <= 1'b0;
      r_r0_dat  <= '0;
      r_r1_dat  <= '0;
      r_r0_ack  <= 1'b0;
      r_r1_ack  <= 1'b0;
    end else begin
      r_grant   <= w_grant_nxt;
      r_we      <= w_we_nxt;
      r_m_adr   <= w_m_adr_nxt;
      r_m_dat   <= w_m_dat_nxt;
      r_m_sel   <= w_m_sel_nxt;
      r_m_write <= w_m_write_nxt;
      r_m_read  <= w_m_read_nxt;
      r_r0_dat  <= w_r0_dat_nxt;
      r_r1_dat  <= w_r1_dat_nxt;
      r_r0_ack  <= w_r0_ack_nxt;
      r_r1_ack  <= w_r1_ack_nxt;
    end
  end

`ifndef T03_WB_ARB_FIXED_PRIO_EN
  // Round-robin pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last <= 1'b1;
    end else begin
      r_last <= w_last_nxt;
    end
  end
`endif

  assign bus.grant_o   = r_grant;
  assign bus.m_adr_o   = r_m_adr;
  assign bus.m_dat_o   = r_m_dat;
  assign bus.m_sel_o   = r_m_sel;
  assign bus.m_write_o = r_m_write;
  assign bus.m_read_o  = r_m_read;
  assign bus.r0_dat_o  = r_r0_dat;
  assign bus.r1_dat_o  = r_r1_dat;
  assign bus.r0_ack_o  = r_r0_ack;
  assign bus.r1_ack_o  = r_r1_ack;

endmodule
`default_nettype wire

// File: tb/tb_t03_wb_request_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_t03_wb_request_arbiter
// Brief    : Self-checking bench for t03_wb_request_arbiter with a small
//            manager/slave model and a transaction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t03_wb_request_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  t03_wb_request_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  t03_wb_request_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  typedef struct {
    logic [1:0]  grant;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          cyc;
  } start_t;

  txn_t   exp_q[$];
  txn_t   pend_q[$];
  start_t start_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] exp_dat0 = '0;
  logic [31:0] exp_dat1 = '0;

  // Read data the model slave returns for an address
  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge CLK) cyc++;

  // Manager/slave model: ack after mdl_delay WAIT cycles, registered read data
  logic        mdl_busy     = 1'b0;
  logic        busy_force   = 1'b0;
  int          mdl_delay    = 0;
  int          mdl_cnt      = 0;
  bit          mdl_pend     = 1'b0;
  bit          mdl_ack_prev = 1'b0;
  logic [31:0] mdl_rd       = '0;
  start_t      s_m;

  assign bus.m_busy_i = mdl_busy | busy_force;

  always @(negedge CLK) begin
    if (RST) begin
      mdl_pend     = 1'b0;
      mdl_ack_prev = 1'b0;
      mdl_busy     = 1'b0;
      bus.m_ack_i  = 1'b0;
      bus.m_dat_i  = '0;
    end else begin
      bus.m_ack_i = 1'b0;
      if (mdl_ack_prev) begin
        bus.m_dat_i  = mdl_rd;
        mdl_busy     = 1'b0;
        mdl_ack_prev = 1'b0;
      end
      if (bus.m_read_o === 1'b1 || bus.m_write_o === 1'b1) begin
        s_m.grant = bus.grant_o;
        s_m.we    = bus.m_write_o;
        s_m.adr   = bus.m_adr_o;
        s_m.dat   = bus.m_dat_o;
        s_m.sel   = bus.m_sel_o;
        s_m.cyc   = cyc;
        start_q.push_back(s_m);
        // Writes still drive junk on the data bus to expose a bad capture
        mdl_rd   = bus.m_write_o ? (32'hBAD0_0000 | {16'h0, bus.m_adr_o[15:0]})
                                 : rdata_of(bus.m_adr_o);
        mdl_cnt  = mdl_delay;
        mdl_pend = 1'b1;
      end else if (mdl_pend) begin
        mdl_busy = 1'b1;
        if (mdl_cnt == 0) begin
          bus.m_ack_i  = 1'b1;
          mdl_ack_prev = 1'b1;
          mdl_pend     = 1'b0;
        end else begin
          mdl_cnt--;
        end
      end
    end
  end

  // Event counters for pulses and acks
  int n_rd = 0, n_wr = 0, n_ack0 = 0, n_ack1 = 0, n_both = 0;
  always @(negedge CLK) begin
    if (bus.m_read_o === 1'b1)  n_rd++;
    if (bus.m_write_o === 1'b1) n_wr++;
    if (bus.r0_ack_o === 1'b1)  n_ack0++;
    if (bus.r1_ack_o === 1'b1)  n_ack1++;
    if (bus.m_read_o === 1'b1 && bus.m_write_o === 1'b1) n_both++;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_ack(input int port, input int budget, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if ((port == 0 ? bus.r0_ack_o : bus.r1_ack_o) === 1'b1) begin
        lat = k;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    n_cmp++; if (bus.grant_o !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", bus.grant_o); end
    n_cmp++; if ({bus.m_read_o, bus.m_write_o, bus.r0_ack_o, bus.r1_ack_o} !== 4'b0000) begin
      n_err++; $display("FAIL reset_pulses: got %b want 0000", {bus.m_read_o, bus.m_write_o, bus.r0_ack_o, bus.r1_ack_o}); end
    n_cmp++; if ({bus.m_adr_o, bus.m_dat_o, bus.m_sel_o} !== 68'h0) begin
      n_err++; $display("FAIL reset_mbus: got %h want 0", {bus.m_adr_o, bus.m_dat_o, bus.m_sel_o}); end
    n_cmp++; if ({bus.r0_dat_o, bus.r1_dat_o} !== 64'h0) begin
      n_err++; $display("FAIL reset_rdat: got %h want 0", {bus.r0_dat_o, bus.r1_dat_o}); end
    RST = 1'b0;
    tick();
    n_cmp++; if (bus.grant_o !== 2'b00) begin n_err++; $display("FAIL reset_idle_grant: got %b want 00", bus.grant_o); end
  endtask

  task automatic test_single_read();
    int rd0, wr0, a0, a1, lat;
    bit ok;
    txn_t e;
    start_t s;
    rd0 = n_rd; wr0 = n_wr; a0 = n_ack0; a1 = n_ack1;
    mdl_delay = 0;
    e.port = 0; e.we = 1'b0; e.adr = 32'h0000_0100; e.dat = 32'h0; e.sel = 4'hF;
    exp_q.push_back(e);
    bus.r0_we_i = 1'b0; bus.r0_adr_i = e.adr; bus.r0_dat_i = e.dat; bus.r0_sel_i = e.sel;
    bus.r0_req_i = 1'b1;
    wait_ack(0, 40, lat, ok);
    bus.r0_req_i = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_ack_seen: got none want ack"); end
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL rd_latency: got %0d want 4", lat); end
    e = exp_q.pop_front();
    exp_dat0 = rdata_of(e.adr);
    n_cmp++; if (bus.r0_dat_o !== exp_dat0) begin n_err++; $display("FAIL rd_data: got %h want %h", bus.r0_dat_o, exp_dat0); end
    n_cmp++;
    if (start_q.size() == 0) begin n_err++; $display("FAIL rd_start: got none want 1"); end
    else begin
      s = start_q.pop_front();
      if (s.grant !== 2'b01 || s.adr !== e.adr || s.we !== 1'b0 || s.sel !== e.sel) begin
        n_err++; $display("FAIL rd_start: got g=%b a=%h we=%b s=%h want g=01 a=%h we=0 s=%h",
                          s.grant, s.adr, s.we, s.sel, e.adr, e.sel); end
    end
    tick();
    n_cmp++; if (bus.r0_ack_o !== 1'b0) begin n_err++; $display("FAIL rd_ack_width: got %b want 0", bus.r0_ack_o); end
    n_cmp++; if ({bus.grant_o, bus.m_adr_o} !== 34'h0) begin
      n_err++; $display("FAIL rd_release: got g=%b a=%h want 0", bus.grant_o, bus.m_adr_o); end
    n_cmp++; if ((n_rd - rd0) != 1 || (n_wr - wr0) != 0) begin
      n_err++; $display("FAIL rd_pulses: got rd=%0d wr=%0d want rd=1 wr=0", n_rd - rd0, n_wr - wr0); end
    n_cmp++; if ((n_ack0 - a0) != 1 || (n_ack1 - a1) != 0) begin
      n_err++; $display("FAIL rd_acks: got a0=%0d a1=%0d want 1 0", n_ack0 - a0, n_ack1 - a1); end
  endtask

  task automatic test_single_write();
    int rd0, wr0, a0, lat;
    bit ok;
    txn_t e;
    start_t s;
    rd0 = n_rd; wr0 = n_wr; a0 = n_ack0;
    mdl_delay = 0;
    e.port = 1; e.we = 1'b1; e.adr = 32'h0000_2004; e.dat = 32'h1234_5678; e.sel = 4'b0011;
    exp_q.push_back(e);
    bus.r1_we_i = 1'b1; bus.r1_adr_i = e.adr; bus.r1_dat_i = e.dat; bus.r1_sel_i = e.sel;
    bus.r1_req_i = 1'b1;
    wait_ack(1, 40, lat, ok);
    bus.r1_req_i = 1'b0;
    n_cmp++; if (!ok || lat != 4) begin n_err++; $display("FAIL wr_latency: got %0d (seen=%0d) want 4", lat, ok); end
    e = exp_q.pop_front();
    n_cmp++;
    if (start_q.size() == 0) begin n_err++; $display("FAIL wr_start: got none want 1"); end
    else begin
      s = start_q.pop_front();
      if (s.grant !== 2'b10 || s.we !== 1'b1 || s.adr !== e.adr || s.dat !== e.dat || s.sel !== e.sel) begin
        n_err++; $display("FAIL wr_start: got g=%b we=%b a=%h d=%h s=%b want g=10 we=1 a=%h d=%h s=%b",
                          s.grant, s.we, s.adr, s.dat, s.sel, e.adr, e.dat, e.sel); end
    end
    n_cmp++; if (bus.r1_dat_o !== exp_dat1) begin n_err++; $display("FAIL wr_r1dat_hold: got %h want %h", bus.r1_dat_o, exp_dat1); end
    n_cmp++; if (bus.r0_dat_o !== exp_dat0) begin n_err++; $display("FAIL wr_r0dat_hold: got %h want %h", bus.r0_dat_o, exp_dat0); end
    tick();
    n_cmp++; if (bus.r1_ack_o !== 1'b0) begin n_err++; $display("FAIL wr_ack_width: got %b want 0", bus.r1_ack_o); end
    n_cmp++; if ((n_wr - wr0) != 1 || (n_rd - rd0) != 0 || (n_ack0 - a0) != 0) begin
      n_err++; $display("FAIL wr_pulses: got wr=%0d rd=%0d a0=%0d want 1 0 0", n_wr - wr0, n_rd - rd0, n_ack0 - a0); end
  endtask

  task automatic test_contention();
    int order[6];
    int c0, c1, n0, n1, done, last_ack;
    txn_t e;
    start_t s;
`ifdef T03_WB_ARB_FIXED_PRIO_EN
    order = '{1, 1, 1, 0, 0, 0};
`else
    order = '{0, 1, 0, 1, 0, 1};
`endif
    mdl_delay = 0;
    RST = 1'b1;
    exp_q.delete(); pend_q.delete(); start_q.delete();
    exp_dat0 = '0; exp_dat1 = '0;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 6; i++) begin
      e.port = order[i]; e.we = 1'b0; e.dat = 32'h0; e.sel = 4'hF;
      if (order[i] == 0) begin e.adr = 32'h0000_1000 + 32'(4 * c0); c0++; end
      else               begin e.adr = 32'h0000_2000 + 32'(4 * c1); c1++; end
      exp_q.push_back(e);
    end
    bus.r0_we_i = 1'b0; bus.r0_adr_i = 32'h0000_1000; bus.r0_sel_i = 4'hF; bus.r0_dat_i = 32'h0;
    bus.r1_we_i = 1'b0; bus.r1_adr_i = 32'h0000_2000; bus.r1_sel_i = 4'hF; bus.r1_dat_i = 32'h0;
    bus.r0_req_i = 1'b1; bus.r1_req_i = 1'b1;
    tick();
    RST = 1'b0;
    n0 = 0; n1 = 0; done = 0; last_ack = -100;
    for (int k = 0; k < 200 && done < 6; k++) begin
      tick();
      if (start_q.size() > 0) begin
        s = start_q.pop_front();
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL cont_start: got extra start want none"); end
        else begin
          e = exp_q.pop_front();
          if (s.grant !== (e.port == 0 ? 2'b01 : 2'b10) || s.adr !== e.adr) begin
            n_err++; $display("FAIL cont_grant: got g=%b a=%h want port %0d a=%h", s.grant, s.adr, e.port, e.adr); end
          pend_q.push_back(e);
        end
        if (last_ack >= 0) begin
          n_cmp++; if (s.cyc - last_ack != 2) begin
            n_err++; $display("FAIL b2b_gap: got %0d want 2", s.cyc - last_ack); end
        end
      end
      if (bus.r0_ack_o === 1'b1 || bus.r1_ack_o === 1'b1) begin
        last_ack = cyc;
        done++;
        n_cmp++;
        if (pend_q.size() == 0) begin n_err++; $display("FAIL cont_ack: got unexpected ack want none"); end
        else begin
          e = pend_q.pop_front();
          if (e.port == 0) begin
            exp_dat0 = rdata_of(e.adr);
            if (bus.r0_ack_o !== 1'b1 || bus.r1_ack_o !== 1'b0 || bus.r0_dat_o !== exp_dat0) begin
              n_err++; $display("FAIL cont_ack0: got a=%b%b d=%h want a=01 d=%h",
                                bus.r1_ack_o, bus.r0_ack_o, bus.r0_dat_o, exp_dat0); end
          end else begin
            exp_dat1 = rdata_of(e.adr);
            if (bus.r1_ack_o !== 1'b1 || bus.r0_ack_o !== 1'b0 || bus.r1_dat_o !== exp_dat1) begin
              n_err++; $display("FAIL cont_ack1: got a=%b%b d=%h want a=10 d=%h",
                                bus.r1_ack_o, bus.r0_ack_o, bus.r1_dat_o, exp_dat1); end
          end
        end
        if (bus.r0_ack_o === 1'b1) begin
          n0++;
          if (n0 == 3) bus.r0_req_i = 1'b0; else bus.r0_adr_i = 32'h0000_1000 + 32'(4 * n0);
        end
        if (bus.r1_ack_o === 1'b1) begin
          n1++;
          if (n1 == 3) bus.r1_req_i = 1'b0; else bus.r1_adr_i = 32'h0000_2000 + 32'(4 * n1);
        end
      end
    end
    bus.r0_req_i = 1'b0; bus.r1_req_i = 1'b0;
    n_cmp++; if (done != 6) begin n_err++; $display("FAIL cont_done: got %0d want 6", done); end
    n_cmp++; if (n_both != 0) begin n_err++; $display("FAIL both_pulses: got %0d want 0", n_both); end
    tick(); tick();
  endtask

  task automatic test_slow_slave();
    int lat, unstable;
    bit ok;
    mdl_delay = 7;
    unstable = 0; ok = 1'b0; lat = 0;
    bus.r0_we_i = 1'b0; bus.r0_adr_i = 32'h0000_0A5C; bus.r0_sel_i = 4'hF;
    bus.r0_req_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.r0_ack_o === 1'b1) begin lat = k; ok = 1'b1; break; end
      if (k >= 1 && bus.m_adr_o !== 32'h0000_0A5C) unstable++;
    end
    bus.r0_req_i = 1'b0;
    n_cmp++; if (!ok || lat != 11) begin n_err++; $display("FAIL slow_latency: got %0d (seen=%0d) want 11", lat, ok); end
    n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL slow_adr_stable: got %0d unstable want 0", unstable); end
    exp_dat0 = rdata_of(32'h0000_0A5C);
    n_cmp++; if (bus.r0_dat_o !== exp_dat0) begin n_err++; $display("FAIL slow_data: got %h want %h", bus.r0_dat_o, exp_dat0); end
    start_q.delete();
    mdl_delay = 0;
    tick();
  endtask

  task automatic test_busy_gate();
    int viol, lat;
    bit ok;
    viol = 0;
    busy_force = 1'b1;
    bus.r0_we_i = 1'b0; bus.r0_adr_i = 32'h0000_0300; bus.r0_sel_i = 4'hF;
    bus.r0_req_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.grant_o !== 2'b00 || bus.m_read_o !== 1'b0 || bus.m_write_o !== 1'b0) viol++;
    end
    busy_force = 1'b0;
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL busy_hold: got %0d grant cycles want 0", viol); end
    wait_ack(0, 40, lat, ok);
    bus.r0_req_i = 1'b0;
    n_cmp++; if (!ok || lat != 4) begin n_err++; $display("FAIL busy_latency: got %0d (seen=%0d) want 4", lat, ok); end
    exp_dat0 = rdata_of(32'h0000_0300);
    n_cmp++; if (bus.r0_dat_o !== exp_dat0) begin n_err++; $display("FAIL busy_data: got %h want %h", bus.r0_dat_o, exp_dat0); end
    start_q.delete();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    bit ok, seen;
    start_t s;
    logic [1:0] want_g;
    mdl_delay = 5;
    bus.r0_we_i = 1'b0; bus.r0_adr_i = 32'h0000_0400; bus.r0_sel_i = 4'hF;
    bus.r0_req_i = 1'b1;
    tick(); tick();   // ISSUE, then WAIT
    n_cmp++; if (bus.grant_o !== 2'b01) begin n_err++; $display("FAIL rmw_pre_grant: got %b want 01", bus.grant_o); end
    #2;
    RST = 1'b1;
    #1;
    n_cmp++; if ({bus.grant_o, bus.m_read_o, bus.m_write_o, bus.r0_ack_o, bus.r1_ack_o} !== 6'b0) begin
      n_err++; $display("FAIL rmw_async_ctl: got %b want 0",
                        {bus.grant_o, bus.m_read_o, bus.m_write_o, bus.r0_ack_o, bus.r1_ack_o}); end
    n_cmp++; if ({bus.m_adr_o, bus.m_dat_o, bus.m_sel_o, bus.r0_dat_o, bus.r1_dat_o} !== 132'h0) begin
      n_err++; $display("FAIL rmw_async_data: got a=%h r0=%h r1=%h want 0", bus.m_adr_o, bus.r0_dat_o, bus.r1_dat_o); end
    exp_dat0 = '0; exp_dat1 = '0;
    bus.r1_we_i = 1'b0; bus.r1_adr_i = 32'h0000_2100; bus.r1_sel_i = 4'hF;
    bus.r1_req_i = 1'b1;
    tick(); tick();
    start_q.delete();
    mdl_delay = 0;
    RST = 1'b0;
`ifdef T03_WB_ARB_FIXED_PRIO_EN
    want_g = 2'b10;
`else
    want_g = 2'b01;
`endif
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (start_q.size() > 0) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL rmw_first_grant: got none want %b", want_g); end
    else begin
      s = start_q.pop_front();
      if (s.grant !== want_g) begin n_err++; $display("FAIL rmw_first_grant: got %b want %b", s.grant, want_g); end
    end
    wait_ack(want_g[1] ? 1 : 0, 40, lat, ok);
    bus.r0_req_i = 1'b0; bus.r1_req_i = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rmw_ack: got none want ack"); end
    tick(); tick();
  endtask

  initial begin
    bus.r0_req_i = 1'b0; bus.r0_we_i = 1'b0; bus.r0_adr_i = '0; bus.r0_dat_i = '0; bus.r0_sel_i = '0;
    bus.r1_req_i = 1'b0; bus.r1_we_i = 1'b0; bus.r1_adr_i = '0; bus.r1_dat_i = '0; bus.r1_sel_i = '0;
    RST = 1'b1;
    tick(); tick();
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_slow_slave();
    test_busy_gate();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
